// File: rtl/ds_issue_push_queue_if.sv
// Decode-to-issue handshake bundle: decoder push side plus the dual-slot issue view.
// dec_valid_x/dec_allowin: a slot is pushed on an edge where it is valid and dec_allowin is high;
// ds_to_issue_valid_x/issue_allowin: every presented slot is consumed on an edge where issue_allowin is high.
interface ds_issue_push_queue_if #(
  parameter int DECODE_BUS_WD = 232,
  parameter int DEPTH         = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                     dec_valid_0;
  logic                     dec_valid_1;
  logic [DECODE_BUS_WD-1:0] dec_bus_0;
  logic [DECODE_BUS_WD-1:0] dec_bus_1;
  logic                     dec_allowin;
  logic                     issue_allowin;
  logic                     ds_to_issue_valid_0;
  logic                     ds_to_issue_valid_1;
  logic [DECODE_BUS_WD-1:0] ds_to_issue_bus_0;
  logic [DECODE_BUS_WD-1:0] ds_to_issue_bus_1;
  logic [PTR_W:0]           count;

  modport slave (
    input  dec_valid_0, dec_valid_1, dec_bus_0, dec_bus_1, issue_allowin,
    output dec_allowin, ds_to_issue_valid_0, ds_to_issue_valid_1,
           ds_to_issue_bus_0, ds_to_issue_bus_1, count
  );

  modport master (
    output dec_valid_0, dec_valid_1, dec_bus_0, dec_bus_1, issue_allowin,
    input  dec_allowin, ds_to_issue_valid_0, ds_to_issue_valid_1,
           ds_to_issue_bus_0, ds_to_issue_bus_1, count
  );
endinterface

// File: rtl/ds_issue_push_queue.sv
// Dual-slot circular queue between decode and issue; presents the two oldest entries in order.
module ds_issue_push_queue #(
  parameter int DECODE_BUS_WD = 232,
  parameter int DEPTH         = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  ds_issue_push_queue_if.slave  q_if
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DECODE_BUS_WD-1:0] r_buf [DEPTH];
  logic [PTR_W:0]           r_head;
  logic [PTR_W:0]           r_tail;

  logic [PTR_W:0]   w_count;
  logic [PTR_W:0]   w_free;
  logic             w_valid_0;
  logic             w_valid_1;
  logic             w_allowin;
  logic [1:0]       w_push_n;
  logic [1:0]       w_pop_n;
  logic [PTR_W-1:0] w_head_idx;
  logic [PTR_W-1:0] w_head_idx1;
  logic [PTR_W-1:0] w_tail_idx;
  logic [PTR_W-1:0] w_tail_idx1;
  logic             w_push_en;

  assign w_count     = r_tail - r_head;
  assign w_free      = (PTR_W+1)'(DEPTH) - w_count;
  assign w_valid_0   = (w_count != '0);
  assign w_valid_1   = (w_count >= (PTR_W+1)'(2));
  // Registered occupancy only, so no combinational path from issue_allowin.
  assign w_allowin   = (w_free >= (PTR_W+1)'(2));

  assign w_head_idx  = r_head[PTR_W-1:0];
  assign w_head_idx1 = w_head_idx + 1'b1;
  assign w_tail_idx  = r_tail[PTR_W-1:0];
  assign w_tail_idx1 = w_tail_idx + 1'b1;

  assign w_push_en   = !flush && w_allowin;

  always_comb begin
    w_push_n = 2'd0;
    w_pop_n  = 2'd0;
    if (w_push_en) begin
      w_push_n = {1'b0, q_if.dec_valid_0} + {1'b0, q_if.dec_valid_1};
    end
    if (!flush && q_if.issue_allowin) begin
      w_pop_n = {1'b0, w_valid_0} + {1'b0, w_valid_1};
    end
  end

  // Payload storage carries no reset; validity comes solely from the pointers.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      if (q_if.dec_valid_0) begin
        r_buf[w_tail_idx] <= q_if.dec_bus_0;
        if (q_if.dec_valid_1) begin
          r_buf[w_tail_idx1] <= q_if.dec_bus_1;
        end
      end else if (q_if.dec_valid_1) begin
        r_buf[w_tail_idx] <= q_if.dec_bus_1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_tail <= r_tail + (PTR_W+1)'(w_push_n);
      r_head <= r_head + (PTR_W+1)'(w_pop_n);
    end
  end

  assign q_if.dec_allowin         = w_allowin;
  assign q_if.ds_to_issue_valid_0 = w_valid_0;
  assign q_if.ds_to_issue_valid_1 = w_valid_1;
  assign q_if.ds_to_issue_bus_0   = w_valid_0 ? r_buf[w_head_idx]  : '0;
  assign q_if.ds_to_issue_bus_1   = w_valid_1 ? r_buf[w_head_idx1] : '0;
  assign q_if.count               = w_count;
endmodule

// File: tb/tb_ds_issue_push_queue.sv
// Directed bench for ds_issue_push_queue: reset, dual/lone pushes, backpressure with wrap, flush.
module tb_ds_issue_push_queue;
  localparam int W     = 232;
  localparam int DEPTH = 4;

  logic clk;
  logic resetn;
  logic flush;
  int   checks;
  int   errors;

  ds_issue_push_queue_if #(.DECODE_BUS_WD(W), .DEPTH(DEPTH)) q_if ();

  ds_issue_push_queue #(.DECODE_BUS_WD(W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .q_if   (q_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pl(input logic [7:0] n);
    pl = {29{n}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [7:0] n0,
                       input logic [7:0] n1, input logic ia);
    q_if.dec_valid_0   = v0;
    q_if.dec_valid_1   = v1;
    q_if.dec_bus_0     = pl(n0);
    q_if.dec_bus_1     = pl(n1);
    q_if.issue_allowin = ia;
  endtask

  task automatic chk_q(input string name, input logic [2:0] cnt, input logic v0,
                       input logic v1, input logic [W-1:0] b0, input logic [W-1:0] b1);
    checks++;
    if (q_if.count !== cnt || q_if.ds_to_issue_valid_0 !== v0 || q_if.ds_to_issue_valid_1 !== v1 ||
        q_if.ds_to_issue_bus_0 !== b0 || q_if.ds_to_issue_bus_1 !== b1) begin
      errors++;
      $display("FAIL %s got cnt=%0d v=%b%b b0=%h b1=%h exp cnt=%0d v=%b%b b0=%h b1=%h", name,
               q_if.count, q_if.ds_to_issue_valid_0, q_if.ds_to_issue_valid_1,
               q_if.ds_to_issue_bus_0[7:0], q_if.ds_to_issue_bus_1[7:0],
               cnt, v0, v1, b0[7:0], b1[7:0]);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    flush  = 1'b0;
    repeat (3) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      step();
    end
    chk_q("reset_hold", 3'd0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (q_if.dec_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_allowin got %b exp 1", q_if.dec_allowin);
    end
    drive(0, 0, 0, 0, 0);
    resetn = 1'b1;
    step();
    drive(1, 1, 8'hA1, 8'hA2, 0);
    step();
    drive(1, 0, 8'hA3, 8'h00, 0);
    step();
    chk_q("reset_prefill", 3'd3, 1'b1, 1'b1, pl(8'hA1), pl(8'hA2));
    drive(0, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    chk_q("reset_async", 3'd0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (q_if.dec_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_allowin got %b exp 1", q_if.dec_allowin);
    end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_dual();
    drive(1, 1, 8'h0A, 8'h0B, 1);
    step();
    chk_q("dual_ab", 3'd2, 1'b1, 1'b1, pl(8'h0A), pl(8'h0B));
    drive(1, 1, 8'h0C, 8'h0D, 1);
    step();
    chk_q("dual_cd", 3'd2, 1'b1, 1'b1, pl(8'h0C), pl(8'h0D));
    drive(0, 0, 0, 0, 1);
    step();
    chk_q("dual_drained", 3'd0, 1'b0, 1'b0, '0, '0);
    step();
    chk_q("empty_issue_allowin", 3'd0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_lone();
    drive(0, 1, 8'h00, 8'h58, 0);
    step();
    chk_q("lone_x", 3'd1, 1'b1, 1'b0, pl(8'h58), '0);
    drive(1, 1, 8'h59, 8'h5A, 0);
    step();
    chk_q("lone_xyz", 3'd3, 1'b1, 1'b1, pl(8'h58), pl(8'h59));
    checks++;
    if (q_if.dec_allowin !== 1'b0) begin
      errors++;
      $display("FAIL lone_allowin got %b exp 0", q_if.dec_allowin);
    end
    drive(0, 0, 0, 0, 1);
    step();
    chk_q("lone_z", 3'd1, 1'b1, 1'b0, pl(8'h5A), '0);
    step();
    chk_q("lone_empty", 3'd0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    logic [7:0] seq;
    logic [W-1:0] e0, e1;
    seq = 8'h10;
    for (int i = 0; i < 4 && q_if.dec_allowin; i++) begin
      drive(1, 1, seq, seq + 8'd1, 0);
      exp_q.push_back(seq);
      exp_q.push_back(seq + 8'd1);
      seq = seq + 8'd2;
      step();
    end
    chk_q("wrap_full", 3'd4, 1'b1, 1'b1, pl(8'h10), pl(8'h11));
    checks++;
    if (q_if.dec_allowin !== 1'b0) begin
      errors++;
      $display("FAIL wrap_full_allowin got %b exp 0", q_if.dec_allowin);
    end
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) begin
        drive(0, 0, 0, 0, 1);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        drive(1, 1, seq, seq + 8'd1, 0);
        exp_q.push_back(seq);
        exp_q.push_back(seq + 8'd1);
        seq = seq + 8'd2;
      end
      step();
      e0 = (exp_q.size() > 0) ? pl(exp_q[0]) : '0;
      e1 = (exp_q.size() > 1) ? pl(exp_q[1]) : '0;
      chk_q($sformatf("wrap_cycle%0d", c), 3'(exp_q.size()), exp_q.size() > 0, exp_q.size() > 1, e0, e1);
    end
    drive(0, 0, 0, 0, 1);
    step();
    step();
    chk_q("wrap_drained", 3'd0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_simul();
    drive(1, 1, 8'h70, 8'h71, 0);
    step();
    chk_q("simul_pre", 3'd2, 1'b1, 1'b1, pl(8'h70), pl(8'h71));
    drive(1, 1, 8'h72, 8'h73, 1);
    step();
    chk_q("simul_swap", 3'd2, 1'b1, 1'b1, pl(8'h72), pl(8'h73));
    drive(0, 0, 0, 0, 1);
    step();
    chk_q("simul_drained", 3'd0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_flush();
    drive(1, 1, 8'h80, 8'h81, 0);
    step();
    drive(1, 0, 8'h82, 8'h00, 0);
    step();
    chk_q("flush_pre", 3'd3, 1'b1, 1'b1, pl(8'h80), pl(8'h81));
    drive(1, 1, 8'h83, 8'h84, 1);
    flush = 1'b1;
    step();
    chk_q("flush_cleared", 3'd0, 1'b0, 1'b0, '0, '0);
    drive(1, 1, 8'h85, 8'h86, 0);
    step();
    chk_q("flush_push_dropped", 3'd0, 1'b0, 1'b0, '0, '0);
    flush = 1'b0;
    drive(1, 1, 8'h87, 8'h88, 0);
    step();
    chk_q("flush_resume", 3'd2, 1'b1, 1'b1, pl(8'h87), pl(8'h88));
    drive(0, 0, 0, 0, 1);
    step();
    chk_q("flush_drained", 3'd0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    flush  = 1'b0;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_dual();
    test_lone();
    test_wrap();
    test_simul();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ds_issue_push_queue.md
# ds_issue_push_queue

Decode-side transmitter for the dual-slot decode→issue handshake. It buffers up to two decoded instructions per cycle from the decoder in a small circular queue. It presents them in program order on the `ds_to_issue_valid_0/1` / `ds_to_issue_bus_0/1` pair, and it retires one or two entries per cycle when the issue stage raises `issue_allowin`. It also enforces the issue-side rule that slot 1 is never valid without slot 0.

## Interface
- `DECODE_BUS_WD`, 232, width of one decoded-instruction bus.
- `DEPTH`, 4, queue entries; power of two, ≥ 2.
- `PTR_W`, log2(DEPTH), index width. Pointers carry one extra wrap bit.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous pipeline flush; clears the queue.
- `dec_valid_0`  in  1  decoder slot 0 valid (older instruction).
- `dec_valid_1`  in  1  decoder slot 1 valid (younger instruction).
- `dec_bus_0`  in  DECODE_BUS_WD  decoder slot 0 payload.
- `dec_bus_1`  in  DECODE_BUS_WD  decoder slot 1 payload.
- `dec_allowin`  out  1  queue can absorb two entries this cycle.
- `issue_allowin`  in  1  issue stage accepts the presented slots this cycle.
- `ds_to_issue_valid_0`  out  1  oldest entry present.
- `ds_to_issue_valid_1`  out  1  second-oldest entry present.
- `ds_to_issue_bus_0`  out  DECODE_BUS_WD  oldest entry payload; 0 when not valid.
- `ds_to_issue_bus_1`  out  DECODE_BUS_WD  second-oldest entry payload; 0 when not valid.
- `count`  out  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH×DECODE_BUS_WD array, not reset. Pointers `head` and `tail` are PTR_W+1 bits. `count` = `tail` − `head`, modulo 2^(PTR_W+1).

Push logic:
- `push_n` = 0 if `flush` or !`dec_allowin`. Otherwise `push_n` = `dec_valid_0` + `dec_valid_1`.
- If both decoder slots are valid, `dec_bus_0` is written at `tail` and `dec_bus_1` at `tail`+1.
- If only one decoder slot is valid, that bus is written at `tail`. A lone `dec_valid_1` is compacted into the next slot.

Pop logic:
- `ds_to_issue_valid_0` = (`count` ≥ 1).
- `ds_to_issue_valid_1` = (`count` ≥ 2). It is never high while `valid_0` is low.
- Bus outputs read `buf[head]` and `buf[head+1]`, each AND-gated with its valid.
- `pop_n` = 0 if `flush` or !`issue_allowin`. Otherwise `pop_n` = `valid_0` + `valid_1`. The issue stage takes every presented slot when `issue_allowin` is high.
- `dec_allowin` = (DEPTH − `count`) ≥ 2. It uses registered occupancy only and has no combinational path from `issue_allowin`.

Update and priority:
- On each edge: `tail` += `push_n`, `head` += `pop_n`. Index bits wrap modulo DEPTH; the wrap bit toggles.
- Priority is reset > `flush` > normal push/pop.
- `flush` sets `head` = `tail` = 0 and discards same-cycle pushes and pops.

## Timing
- Reset (`resetn` low, asynchronous): `head` = `tail` = 0, `count` = 0, `dec_allowin` = 1, both issue valids = 0, both buses = 0.
- Release is synchronous to the next `clk` edge.
- Push latency: an entry written at edge N appears on `ds_to_issue_*` after edge N. There is no same-cycle bypass through an empty queue.
- Pop is immediate: an entry accepted at edge N is replaced by the next entry after edge N.
- Simultaneous push and pop: both happen. Occupancy changes by `push_n` − `pop_n`, and the queue never overflows.
  - Reason: a push requires ≥ 2 free slots measured before the pop.
- Full boundary (`count` ≥ DEPTH−1): `dec_allowin` = 0 and the decoder holds its bus. Pops still proceed.
- Empty boundary: both valids low, buses 0, `issue_allowin` has no effect.
- Pointer wrap: correct across the DEPTH boundary. Example: `tail` index DEPTH−1 with a dual push writes slots DEPTH−1 and 0.
- Flush mid-stream: on the next cycle valids = 0 and `count` = 0. Pushes resume the cycle after.

## Test plan
- **Reset.** Hold `resetn` low for 3 cycles with random inputs, then assert it low asynchronously mid-cycle while the queue holds 3 entries. Required: `count` = 0 and valids = 0 immediately, buses 0, `dec_allowin` = 1.
- **Dual in, dual out.** Push A,B then C,D with `issue_allowin` = 1. Required:
  - Cycle 1: slots show A,B.
  - Cycle 2: slots show C,D.
  - `count` is never > 2.
- **Lone slot 1 and odd occupancy.** Push `dec_valid_1` only, with payload X. Required: next cycle `valid_0` = 1 with `bus_0` = X, and `valid_1` = 0. Push Y,Z with `issue_allowin` = 0. Required: `count` = 3 and `dec_allowin` = 0.
- **Backpressure and wrap.** With DEPTH = 4, hold `issue_allowin` = 0 and push pairs until `dec_allowin` = 0 (`count` = 4). Then alternate one-cycle pops with refills for 12 cycles. Required: FIFO order is preserved across pointer wrap, with no loss or duplication.
- **Simultaneous push and pop.** Start at `count` = 2, then push 2 and pop 2 in the same cycle. Required: `count` stays 2 and the new pair is presented next cycle.
- **Flush.** Start at `count` = 3, then assert `flush` together with `dec_valid_0/1` = 1 and `issue_allowin` = 1. Required: next cycle `count` = 0, no valid outputs, and the flushed-cycle push is dropped.
